// File: rtl/excess3_to_bcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : excess3_to_bcd_pkg                                              |
// | Purpose  : Shared constants and the digit type for the Excess-3 to BCD     |
// |            converter.                                                      |
// | Contents : E3_MIN / E3_MAX bound the legal Excess-3 code range,            |
// |            E3_BIAS is the offset removed from each code, and BCD_INVALID   |
// |            is the marker driven for an illegal code.                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package excess3_to_bcd_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t E3_MIN      = 4'd3;
  localparam digit_t E3_MAX      = 4'd12;
  localparam digit_t E3_BIAS     = 4'd3;
  localparam digit_t BCD_INVALID = 4'hF;

endpackage : excess3_to_bcd_pkg
`default_nettype wire

// File: rtl/excess3_to_bcd_digit_conv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : excess3_digit_conv                                              |
// | Purpose  : Purely combinational single-digit Excess-3 to BCD conversion.   |
// | Ports    : i_e3   - 4-bit Excess-3 code                                    |
// |            o_bcd  - 4-bit BCD digit (BCD_INVALID when the code is illegal) |
// |            o_err  - high when i_e3 is not a legal Excess-3 code            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module excess3_digit_conv
  import excess3_to_bcd_pkg::*;
(
  input  digit_t i_e3,
  output digit_t o_bcd,
  output logic   o_err
);

  logic w_legal;

  assign w_legal = (i_e3 >= E3_MIN) && (i_e3 <= E3_MAX);

  // The subtraction only ever sees legal codes, so it never wraps.
  assign o_bcd = w_legal ? digit_t'(i_e3 - E3_BIAS) : BCD_INVALID;
  assign o_err = ~w_legal;

endmodule : excess3_digit_conv
`default_nettype wire

// File: rtl/excess3_to_bcd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : excess3_to_bcd                                                  |
// | Purpose  : Converts DIGITS packed Excess-3 digits to packed 8421 BCD with  |
// |            per-digit legality checking and a one-cycle registered result.  |
// | Ports    : clk       - system clock, rising edge                           |
// |            rst_n     - asynchronous active-low reset                       |
// |            in_valid  - Excess3 carries a word this cycle                   |
// |            Excess3   - packed input digits, digit 0 in bits [3:0]          |
// |            out_valid - BCD / digit_err / any_err hold a fresh result       |
// |            BCD       - packed BCD digits, same packing as Excess3          |
// |            digit_err - bit i set when input digit i was illegal            |
// |            any_err   - OR of digit_err                                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module excess3_to_bcd
  import excess3_to_bcd_pkg::*;
#(
  parameter int DIGITS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [4*DIGITS-1:0]   Excess3,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   BCD,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  any_err
);

  logic [4*DIGITS-1:0] w_bcd;
  logic [DIGITS-1:0]   w_err;

  logic                r_out_valid;
  logic [4*DIGITS-1:0] r_bcd;
  logic [DIGITS-1:0]   r_digit_err;
  logic                r_any_err;

  // Digits are fully independent: no carry or borrow crosses a nibble.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    excess3_digit_conv u_conv (
      .i_e3  (Excess3[4*gi +: 4]),
      .o_bcd (w_bcd[4*gi +: 4]),
      .o_err (w_err[gi])
    );
  end

  // Result registers update only on an accepted word, so data lines driven
  // while in_valid is low (even X) never reach the held outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_bcd       <= '0;
      r_digit_err <= '0;
      r_any_err   <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_bcd       <= w_bcd;
        r_digit_err <= w_err;
        r_any_err   <= |w_err;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign BCD       = r_bcd;
  assign digit_err = r_digit_err;
  assign any_err   = r_any_err;

endmodule : excess3_to_bcd
`default_nettype wire

// File: tb/tb_excess3_to_bcd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_excess3_to_bcd                                               |
// | Purpose  : Self-checking bench for excess3_to_bcd, single- and             |
// |            three-digit instances, directed and random stimulus.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_excess3_to_bcd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b1;
  logic [3:0]  e3_1 = 4'b0111;
  logic [11:0] e3_3 = 12'h777;

  logic        ov1, ae1;
  logic [3:0]  bcd1;
  logic [0:0]  de1;
  logic        ov3, ae3;
  logic [11:0] bcd3;
  logic [2:0]  de3;

  int total = 0;
  int bad   = 0;

  // Expected state, maintained from the conversion rules.
  logic        x_v;
  logic [3:0]  x_b1;
  logic [0:0]  x_e1;
  logic [11:0] x_b3;
  logic [2:0]  x_e3;

  always #5 clk = ~clk;

  excess3_to_bcd #(.DIGITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .Excess3(e3_1),
    .out_valid(ov1), .BCD(bcd1), .digit_err(de1), .any_err(ae1)
  );

  excess3_to_bcd #(.DIGITS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .Excess3(e3_3),
    .out_valid(ov3), .BCD(bcd3), .digit_err(de3), .any_err(ae3)
  );

  function automatic logic [3:0] ref_digit(input int code);
    if (code >= 3 && code <= 12) return 4'(code - 3);
    return 4'hF;
  endfunction

  function automatic logic ref_bad(input int code);
    return (code < 3) || (code > 12);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ov1"},  16'(ov1),  16'(x_v));
    chk({tag, ".bcd1"}, 16'(bcd1), 16'(x_b1));
    chk({tag, ".de1"},  16'(de1),  16'(x_e1));
    chk({tag, ".ae1"},  16'(ae1),  16'(|x_e1));
    chk({tag, ".ov3"},  16'(ov3),  16'(x_v));
    chk({tag, ".bcd3"}, 16'(bcd3), 16'(x_b3));
    chk({tag, ".de3"},  16'(de3),  16'(x_e3));
    chk({tag, ".ae3"},  16'(ae3),  16'(|x_e3));
  endtask

  task automatic clear_exp();
    x_v = 1'b0; x_b1 = '0; x_e1 = '0; x_b3 = '0; x_e3 = '0;
  endtask

  // Drive one word, advance one edge, update expectations, check.
  task automatic step(input string tag, input logic v, input logic [3:0] d1,
                      input logic [11:0] d3);
    logic [3:0]  s1;
    logic [11:0] s3;
    s1 = d1;
    s3 = d3;
    in_valid = v;
    e3_1 = d1;
    e3_3 = d3;
    @(posedge clk);
    #1;
    x_v = v;
    if (v) begin
      x_b1    = ref_digit(int'(s1));
      x_e1[0] = ref_bad(int'(s1));
      for (int i = 0; i < 3; i++) begin
        x_b3[4*i +: 4] = ref_digit(int'(s3[4*i +: 4]));
        x_e3[i]        = ref_bad(int'(s3[4*i +: 4]));
      end
    end
    check_all(tag);
  endtask

  initial begin
    logic [3:0] invl [6];
    invl = '{4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2};
    clear_exp();

    // Reset held with a valid word presented.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    step("release", 1'b1, 4'b0111, 12'h777);

    // Full legal sweep on digit 0 (and across all three digits).
    for (int c = 3; c <= 12; c++)
      step("sweep", 1'b1, 4'(c), {4'(c), 4'(15 - c), 4'(c)});

    // Illegal codes.
    for (int k = 0; k < 6; k++)
      step("invalid", 1'b1, invl[k], {invl[k], 4'h5, invl[k]});

    // Hold when in_valid is low, including undriven data.
    step("hold_load", 1'b1, 4'b1010, 12'hA5C);
    step("hold", 1'b0, 4'b0101, 12'h555);
    step("hold_x", 1'b0, 4'bxxxx, 12'hxxx);

    // Multi-digit mixed legality.
    step("multi", 1'b1, 4'b0100, 12'b0100_1100_1101);

    // Async reset between edges during back-to-back traffic.
    step("b2b0", 1'b1, 4'h9, 12'h9AB);
    step("b2b1", 1'b1, 4'h4, 12'h456);
    #2;
    rst_n = 1'b0;
    #1;
    clear_exp();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst_n = 1'b1;
    step("post_rst", 1'b1, 4'h6, 12'h6C3);

    // Random traffic.
    for (int n = 0; n < 200; n++)
      step("rand", 1'($urandom_range(0, 3) != 0), 4'($urandom), 12'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound the run in case stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_excess3_to_bcd
`default_nettype wire
